// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial pattern generator: state encoding,
// prescaler defaults and the bit-index to 7-segment mapping.
package seq_gen_pkg;

  localparam int unsigned DIV_DEFAULT = 20000000;
  localparam int unsigned PRESCALE_W  = 27;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Active-low segments, packed as {a,b,c,d,e,f,g}.
  function automatic logic [6:0] digit_to_seg(input logic [2:0] digit);
    logic [6:0] seg;
    case (digit)
      3'd0:    seg = 7'b0000001;
      3'd1:    seg = 7'b1001111;
      3'd2:    seg = 7'b0010010;
      3'd3:    seg = 7'b0000110;
      3'd4:    seg = 7'b1001100;
      3'd5:    seg = 7'b0100100;
      3'd6:    seg = 7'b0100000;
      default: seg = 7'b0001111;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider that pulses tick once every DIV cycles while enabled
// and parks at zero when disabled, so every frame starts on a fresh bit period.
module tick_prescaler
  import seq_gen_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [PRESCALE_W-1:0] TERM = PRESCALE_W'(DIV - 1);

  logic [PRESCALE_W-1:0] count;

  assign tick = en && (count == TERM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!en || tick) begin
      count <= '0;
    end else begin
      count <= count + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/sequence_generator.sv
// Serialises a captured 8-bit pattern MSB-first, one bit per DIV clocks,
// optionally looping, and shows the current bit index on a 7-segment digit.
module sequence_generator
  import seq_gen_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] pattern,
  input  logic       repeat_en,
  output logic       x_out,
  output logic       valid,
  output logic       busy,
  output logic       done,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g
);

  state_t     state, state_next;
  logic [2:0] idx, idx_next, idx_inc, disp;
  logic [7:0] captured, captured_next;
  logic       x_next, valid_next, busy_next, done_next;
  logic [6:0] seg, seg_next;
  logic       tick;

  tick_prescaler #(.DIV(DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (state == SHIFT),
    .tick (tick)
  );

  assign idx_inc = idx + 3'd1;

  always_comb begin
    state_next    = state;
    idx_next      = idx;
    captured_next = captured;
    x_next        = x_out;
    valid_next    = valid;
    busy_next     = busy;
    done_next     = 1'b0;
    case (state)
      SHIFT: begin
        if (tick) begin
          if (idx != 3'd7) begin
            idx_next = idx_inc;
            x_next   = captured[3'd7 - idx_inc];
          end else if (repeat_en) begin
            // Wrap straight into the next frame with no idle bit in between.
            idx_next  = 3'd0;
            x_next    = captured[7];
            done_next = 1'b1;
          end else begin
            state_next = DONE;
            x_next     = 1'b1;
            valid_next = 1'b0;
            done_next  = 1'b1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
        x_next     = 1'b1;
        valid_next = 1'b0;
        busy_next  = 1'b0;
      end
      default: begin
        x_next     = 1'b1;
        valid_next = 1'b0;
        busy_next  = 1'b0;
        if (start) begin
          state_next    = SHIFT;
          captured_next = pattern;
          idx_next      = 3'd0;
          x_next        = pattern[7];
          valid_next    = 1'b1;
          busy_next     = 1'b1;
        end
      end
    endcase

    case (state_next)
      SHIFT:   disp = idx_next;
      DONE:    disp = 3'd7;
      default: disp = 3'd0;
    endcase
    seg_next = digit_to_seg(disp);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= 3'd0;
      captured <= 8'd0;
      x_out    <= 1'b1;
      valid    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      seg      <= 7'b0000001;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      captured <= captured_next;
      x_out    <= x_next;
      valid    <= valid_next;
      busy     <= busy_next;
      done     <= done_next;
      seg      <= seg_next;
    end
  end

  assign {a, b, c, d, e, f, g} = seg;

endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench for sequence_generator with a 4-clock bit period; observed
// word is {x_out, valid, busy, done, a..g}.
module tb_sequence_generator;

  localparam int DIV = 4;
  localparam logic [6:0] SEG [8] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                     7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111};
  localparam logic [10:0] IDLE_W = {4'b1000, 7'b0000001};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] pattern = 8'h00;
  logic       repeat_en = 1'b0;
  logic       x_out, valid, busy, done, a, b, c, d, e, f, g;

  int vectors = 0;
  int miscompares = 0;

  sequence_generator #(.DIV(DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .repeat_en(repeat_en),
    .x_out(x_out), .valid(valid), .busy(busy), .done(done),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] obs();
    return {x_out, valid, busy, done, a, b, c, d, e, f, g};
  endfunction

  // Expected word k edges after the accepting edge of a single, non-repeating frame.
  function automatic logic [10:0] frame_exp(input logic [7:0] pat, input int k);
    if (k < 32) return {pat[7 - k / 4], 1'b1, 1'b1, 1'b0, SEG[k / 4]};
    if (k == 32) return {4'b1011, SEG[7]};
    return IDLE_W;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    vectors++;
    if (obs() !== IDLE_W) begin
      miscompares++;
      $display("FAIL reset_state: got %b expected %b", obs(), IDLE_W);
    end
    rst = 1'b0;
  endtask

  task automatic test_frame(input logic [7:0] pat);
    start = 1'b1;
    pattern = pat;
    for (int k = 0; k <= 35; k++) begin
      step();
      if (k == 0) begin
        start = 1'b0;
        pattern = ~pat;
      end
      vectors++;
      if (obs() !== frame_exp(pat, k)) begin
        miscompares++;
        $display("FAIL frame_%h k=%0d: got %b expected %b", pat, k, obs(), frame_exp(pat, k));
      end
    end
  endtask

  task automatic test_ignore_start();
    start = 1'b1;
    pattern = 8'h77;
    for (int k = 0; k <= 45; k++) begin
      step();
      if (k == 0) start = 1'b0;
      if (k == 8) begin
        start = 1'b1;
        pattern = 8'hA5;
      end
      if (k == 12) start = 1'b0;
      vectors++;
      if (obs() !== frame_exp(8'h77, k)) begin
        miscompares++;
        $display("FAIL ignore_start k=%0d: got %b expected %b", k, obs(), frame_exp(8'h77, k));
      end
    end
  endtask

  task automatic test_repeat();
    logic [10:0] exp;
    int j;
    repeat_en = 1'b1;
    start = 1'b1;
    pattern = 8'h0F;
    for (int k = 0; k <= 129; k++) begin
      step();
      if (k == 0) begin
        start = 1'b0;
        pattern = 8'hC3;
      end
      if (k < 128) begin
        j = k % 32;
        exp = {pattern_bit(j), 1'b1, 1'b1, (j == 0 && k != 0), SEG[j / 4]};
      end else begin
        exp = frame_exp(8'h0F, k - 96);
      end
      vectors++;
      if (obs() !== exp) begin
        miscompares++;
        $display("FAIL repeat k=%0d: got %b expected %b", k, obs(), exp);
      end
      if (k == 100) repeat_en = 1'b0;
    end
  endtask

  function automatic logic pattern_bit(input int j);
    logic [7:0] p;
    p = 8'h0F;
    return p[7 - j / 4];
  endfunction

  task automatic test_reset_mid();
    start = 1'b1;
    pattern = 8'h77;
    for (int k = 0; k <= 13; k++) begin
      step();
      if (k == 0) start = 1'b0;
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (obs() !== IDLE_W) begin
      miscompares++;
      $display("FAIL reset_mid: got %b expected %b", obs(), IDLE_W);
    end
    step();
    rst = 1'b0;
    start = 1'b1;
    pattern = 8'h77;
    for (int k = 0; k <= 33; k++) begin
      step();
      if (k == 0) start = 1'b0;
      vectors++;
      if (obs() !== frame_exp(8'h77, k)) begin
        miscompares++;
        $display("FAIL after_reset k=%0d: got %b expected %b", k, obs(), frame_exp(8'h77, k));
      end
    end
  endtask

  task automatic test_done_start();
    start = 1'b1;
    pattern = 8'h3C;
    for (int k = 0; k <= 33; k++) begin
      step();
      if (k == 0) start = 1'b0;
      if (k == 32) begin
        start = 1'b1;
        pattern = 8'h81;
      end
      vectors++;
      if (obs() !== frame_exp(8'h3C, k)) begin
        miscompares++;
        $display("FAIL done_start k=%0d: got %b expected %b", k, obs(), frame_exp(8'h3C, k));
      end
    end
    for (int k = 0; k <= 33; k++) begin
      step();
      if (k == 0) start = 1'b0;
      vectors++;
      if (obs() !== frame_exp(8'h81, k)) begin
        miscompares++;
        $display("FAIL late_start k=%0d: got %b expected %b", k, obs(), frame_exp(8'h81, k));
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame(8'h77);
    test_frame(8'hB2);
    test_ignore_start();
    test_repeat();
    test_reset_mid();
    test_done_start();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
